// File: rtl/booth_r8_pkg.sv
// rtl/booth_r8_pkg.sv - shared state encoding, digit-select encoding and sizing helper for the radix-8 Booth multiplier
package booth_r8_pkg;

    // Controller state encoding, also exposed on the state output
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Magnitude of the selected Booth multiple; the sign travels separately as neg
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_M1   = 3'd1,
        SEL_M2   = 3'd2,
        SEL_M3   = 3'd3,
        SEL_M4   = 3'd4
    } sel_e;

    // Number of radix-8 digits needed to cover WIDTH bits plus one sign-guard bit
    function automatic int ndig(input int width);
        return (width + 3) / 3;
    endfunction

endpackage

// File: rtl/booth_r8_encoder.sv
// rtl/booth_r8_encoder.sv - maps a 4-bit Booth triplet {b2,b1,b0,b-1} to a multiple select and negate flag
module booth_r8_encoder
    import booth_r8_pkg::*;
(
    input  logic [3:0] trip_i,
    output sel_e       sel_o,
    output logic       neg_o
);

    // Digit d = -4*b2 + 2*b1 + b0 + b-1, split into |d| and sign; -0 is reported as plain zero
    always_comb begin
        sel_o = SEL_ZERO;
        neg_o = 1'b0;
        case (trip_i)
            4'b0000, 4'b1111: begin sel_o = SEL_ZERO; neg_o = 1'b0; end
            4'b0001, 4'b0010: begin sel_o = SEL_M1;   neg_o = 1'b0; end
            4'b0011, 4'b0100: begin sel_o = SEL_M2;   neg_o = 1'b0; end
            4'b0101, 4'b0110: begin sel_o = SEL_M3;   neg_o = 1'b0; end
            4'b0111:          begin sel_o = SEL_M4;   neg_o = 1'b0; end
            4'b1000:          begin sel_o = SEL_M4;   neg_o = 1'b1; end
            4'b1001, 4'b1010: begin sel_o = SEL_M3;   neg_o = 1'b1; end
            4'b1011, 4'b1100: begin sel_o = SEL_M2;   neg_o = 1'b1; end
            4'b1101, 4'b1110: begin sel_o = SEL_M1;   neg_o = 1'b1; end
            default:          begin sel_o = SEL_ZERO; neg_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/booth_r8_seq_mult.sv
// rtl/booth_r8_seq_mult.sv - sequential radix-8 Booth multiplier, one digit per clock, start/busy/done handshake
module booth_r8_seq_mult
    import booth_r8_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           state_o
);

    localparam int NDIG = ndig(WIDTH);
    localparam int PW   = 2 * WIDTH;
    localparam int YW   = 3 * NDIG + 1;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic            sgn_q;
    logic [PW-1:0]   m_q, m3_q, acc_q, prod_q;
    logic [YW-1:0]   y_q;
    logic [CW-1:0]   cnt_q;

    logic            accept;
    sel_e            sel;
    logic            neg;
    logic [PW-1:0]   m_ext, mult, addend, acc_sum;
    logic [YW-2:0]   y_ext;

    // New requests are only taken when no multiplication is in flight
    assign accept = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state logic: LOAD lasts one cycle, RUN lasts one cycle per digit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST_DIG) state_d = ST_DONE;
            ST_DONE: state_d = start_i ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Operand extension; the multiplicand only needs 2*WIDTH bits since the sum wraps there anyway
    always_comb begin
        m_ext = sgn_q ? {{(PW - WIDTH){a_q[WIDTH-1]}}, a_q} : {{(PW - WIDTH){1'b0}}, a_q};
        y_ext = sgn_q ? {{(YW - 1 - WIDTH){b_q[WIDTH-1]}}, b_q} : {{(YW - 1 - WIDTH){1'b0}}, b_q};
    end

    // The low four multiplier bits always hold the current triplet because y_q shifts right by 3 per digit
    booth_r8_encoder u_enc (
        .trip_i (y_q[3:0]),
        .sel_o  (sel),
        .neg_o  (neg)
    );

    // Pick the multiple (already aligned to the current digit) and negate as invert-plus-one
    always_comb begin
        mult = '0;
        case (sel)
            SEL_ZERO: mult = '0;
            SEL_M1:   mult = m_q;
            SEL_M2:   mult = m_q << 1;
            SEL_M3:   mult = m3_q;
            SEL_M4:   mult = m_q << 2;
            default:  mult = '0;
        endcase
        addend  = neg ? (~mult + PW'(1)) : mult;
        acc_sum = acc_q + addend;
    end

    // Operand capture, LOAD preparation and per-digit accumulation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            m_q    <= '0;
            m3_q   <= '0;
            acc_q  <= '0;
            prod_q <= '0;
            y_q    <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                a_q   <= a_i;
                b_q   <= b_i;
                sgn_q <= signed_i;
            end
            case (state_q)
                ST_LOAD: begin
                    m_q   <= m_ext;
                    m3_q  <= m_ext + (m_ext << 1);
                    y_q   <= {y_ext, 1'b0};
                    acc_q <= '0;
                    cnt_q <= '0;
                end
                ST_RUN: begin
                    acc_q <= acc_sum;
                    m_q   <= m_q << 3;
                    m3_q  <= m3_q << 3;
                    y_q   <= y_q >> 3;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_DIG) prod_q <= acc_sum;
                end
                default: ;
            endcase
        end
    end

    assign state_o   = state_q;
    assign busy_o    = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done_o    = (state_q == ST_DONE);
    assign product_o = prod_q;

endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// tb/tb_booth_r8_seq_mult.sv - self-checking bench for booth_r8_seq_mult at WIDTH 4, 16 and 32
module tb_booth_r8_seq_mult;

    logic clk = 1'b0;
    logic rst, start, sgn;
    logic [3:0]  a4, b4;
    logic [15:0] a16, b16;
    logic [31:0] a32, b32;
    logic [7:0]  p4;
    logic [31:0] p16;
    logic [63:0] p32;
    logic busy4, done4, busy16, done16, busy32, done32;
    logic [1:0] st4, st16, st32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_r8_seq_mult #(.WIDTH(4)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn), .a_i(a4), .b_i(b4),
        .product_o(p4), .busy_o(busy4), .done_o(done4), .state_o(st4));
    booth_r8_seq_mult #(.WIDTH(16)) u16 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn), .a_i(a16), .b_i(b16),
        .product_o(p16), .busy_o(busy16), .done_o(done16), .state_o(st16));
    booth_r8_seq_mult #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn), .a_i(a32), .b_i(b32),
        .product_o(p32), .busy_o(busy32), .done_o(done32), .state_o(st32));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact product of w-bit operands, interpreted per mode, truncated to 2*w bits
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b, input bit sg);
        longint av, bv;
        logic [63:0] p, mask;
        av = longint'(a);
        bv = longint'(b);
        if (sg) begin
            if (a[w-1]) av = av - (longint'(1) << w);
            if (b[w-1]) bv = bv - (longint'(1) << w);
        end
        p = av * bv;
        mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return p & mask;
    endfunction

    // Launch one 16-bit operation and return edges from accept to Done plus cycles spent busy
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit sg,
                         output int edges, output int busy_cycles);
        a16 = a; b16 = b; sgn = sg; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        busy_cycles = 0;
        while (!done16 && edges < 40) begin
            if (busy16) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sgn = 1'b0;
        a4 = '0; b4 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (st16 !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", st16); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy16); end
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done16); end
        checks++; if (p16 !== 32'd0) begin errors++; $display("FAIL reset_product got %h want 0", p16); end
        checks++; if (p4 !== 8'd0) begin errors++; $display("FAIL reset_product4 got %h want 0", p4); end
        checks++; if (p32 !== 64'd0) begin errors++; $display("FAIL reset_product32 got %h want 0", p32); end
    endtask

    task automatic test_basic();
        int edges, bc;
        run16(16'd3, 16'd5, 1'b1, edges, bc);
        checks++; if (edges !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", edges); end
        checks++; if (bc !== 7) begin errors++; $display("FAIL basic_busy_cycles got %0d want 7", bc); end
        checks++; if (p16 !== 32'h0000000F) begin errors++; $display("FAIL basic_product got %h want 0000000f", p16); end
        checks++; if (st16 !== 2'b11) begin errors++; $display("FAIL basic_done_state got %b want 11", st16); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL basic_busy_with_done got %b want 0", busy16); end
        tick();
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done16); end
        checks++; if (st16 !== 2'b00) begin errors++; $display("FAIL basic_back_to_idle got %b want 00", st16); end
        checks++; if (p16 !== 32'h0000000F) begin errors++; $display("FAIL basic_product_hold got %h want 0000000f", p16); end
    endtask

    task automatic test_corner_products();
        logic [15:0] ta [4] = '{16'hFFF9, 16'h8000, 16'hFFFF, 16'hFFFF};
        logic [15:0] tb_ [4] = '{16'h0009, 16'h8000, 16'hFFFF, 16'hFFFF};
        bit          ts [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] te [4] = '{32'hFFFFFFC1, 32'h40000000, 32'hFFFE0001, 32'h00000001};
        int edges, bc;
        for (int i = 0; i < 4; i++) begin
            run16(ta[i], tb_[i], ts[i], edges, bc);
            checks++;
            if (p16 !== te[i] || done16 !== 1'b1) begin
                errors++;
                $display("FAIL corner_%0d product got %h done %b want %h done 1", i, p16, done16, te[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int edges, bc;
        logic [63:0] r;
        a16 = 16'd1234; b16 = 16'hFFB3; sgn = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++; if (st16 !== 2'b10) begin errors++; $display("FAIL midrun_in_run got %b want 10", st16); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (st16 !== 2'b00) begin errors++; $display("FAIL midrun_state got %b want 00", st16); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL midrun_busy got %b want 0", busy16); end
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL midrun_done got %b want 0", done16); end
        checks++; if (p16 !== 32'd0) begin errors++; $display("FAIL midrun_product got %h want 0", p16); end
        run16(16'd11, 16'hFFF3, 1'b1, edges, bc);
        r = ref_mul(16, 32'd11, 32'h0000FFF3, 1'b1);
        checks++;
        if (p16 !== r[31:0] || edges !== 8) begin
            errors++;
            $display("FAIL midrun_restart product %h edges %0d want %h edges 8", p16, edges, r[31:0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int edges;
        a16 = 16'd2; b16 = 16'd3; sgn = 1'b0; start = 1'b1;
        tick();
        edges = 1;
        while (!done16 && edges < 40) begin
            if (edges == 3) begin a16 = 16'd4; b16 = 16'd5; end
            tick();
            edges++;
        end
        checks++; if (edges !== 8) begin errors++; $display("FAIL b2b_first_latency got %0d want 8", edges); end
        checks++; if (p16 !== 32'd6) begin errors++; $display("FAIL b2b_first_product got %0d want 6", p16); end
        tick();
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got %b want 0", done16); end
        checks++; if (st16 !== 2'b01) begin errors++; $display("FAIL b2b_reload got %b want 01", st16); end
        edges = 1;
        while (!done16 && edges < 40) begin
            tick();
            edges++;
        end
        start = 1'b0;
        checks++; if (edges !== 8) begin errors++; $display("FAIL b2b_second_latency got %0d want 8", edges); end
        checks++; if (p16 !== 32'd20) begin errors++; $display("FAIL b2b_second_product got %0d want 20", p16); end
        for (int i = 0; i < 20; i++) tick();
    endtask

    task automatic test_random();
        int n;
        logic [63:0] r4, r16, r32;
        for (int it = 0; it < 1200; it++) begin
            sgn = 1'($urandom_range(0, 1));
            a4 = 4'($urandom); b4 = 4'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            a32 = $urandom; b32 = $urandom;
            case (it % 8)
                0: begin a4 = '1; b4 = '1; a16 = '1; b16 = '1; a32 = '1; b32 = '1; end
                1: begin a4 = 4'h8; b4 = 4'h8; a16 = 16'h8000; b16 = 16'h8000; a32 = 32'h80000000; b32 = 32'h80000000; end
                2: begin a4 = 4'h7; b4 = 4'h8; a16 = 16'h7FFF; b16 = 16'h8000; a32 = 32'h7FFFFFFF; b32 = 32'h80000000; end
                3: begin b4 = '0; b16 = '0; b32 = '0; end
                default: ;
            endcase
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 1;
            while (!done32 && n < 40) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 40) begin errors++; $display("FAIL rand_timeout iter %0d done32 %b want 1", it, done32); end
            r4  = ref_mul(4,  {28'd0, a4},  {28'd0, b4},  sgn);
            r16 = ref_mul(16, {16'd0, a16}, {16'd0, b16}, sgn);
            r32 = ref_mul(32, a32, b32, sgn);
            checks++;
            if (p4 !== r4[7:0]) begin
                errors++;
                $display("FAIL rand_w4 iter %0d s %0b a %h b %h got %h want %h", it, sgn, a4, b4, p4, r4[7:0]);
            end
            checks++;
            if (p16 !== r16[31:0]) begin
                errors++;
                $display("FAIL rand_w16 iter %0d s %0b a %h b %h got %h want %h", it, sgn, a16, b16, p16, r16[31:0]);
            end
            checks++;
            if (p32 !== r32) begin
                errors++;
                $display("FAIL rand_w32 iter %0d s %0b a %h b %h got %h want %h", it, sgn, a32, b32, p32, r32);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corner_products();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
